// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry, the write-port bundle and the
// round-robin pointer wrap helper used by the arbiters.
package rf_pkg;

  localparam int RF_ADDR_W   = 3;
  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 8;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = 3'd0;

  typedef struct packed {
    logic                 wen;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_port_t;

  // Positions scanned never exceed 2*n-1, so a single subtraction wraps them.
  function automatic logic [2:0] rr_wrap(input logic [2:0] pos, input logic [2:0] n);
    if (pos >= n) begin
      rr_wrap = pos - n;
    end else begin
      rr_wrap = pos;
    end
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Pure round-robin arbiter: one-hot grant to the first valid requester found
// scanning upward from ptr_i+1, all-zero when disabled or nothing is valid.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [1:0]   ptr_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);

  logic       found_s;
  logic [2:0] pos_s;

  // Priority scan in rotated order; the first hit wins.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    pos_s   = 3'd0;
    for (int k = 1; k <= N; k++) begin
      pos_s = rr_wrap({1'b0, ptr_i} + 3'(k), 3'(N));
      for (int j = 0; j < N; j++) begin
        if (en_i && !found_s && valid_i[j] && (pos_s == 3'(j))) begin
          grant_o[j] = 1'b1;
          found_s    = 1'b1;
        end else begin
          grant_o[j] = grant_o[j];
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ
// producers. Define RF_ZERO_DROP_EN to suppress WEN for accepted writes to R0.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  output logic                      WEN,
  output logic [ADDR_W-1:0]         RW,
  output logic [DATA_W-1:0]         busW,
  output logic [1:0]                grant_id,
  output logic                      busy
);

  logic [NUM_REQ-1:0] grant_s;
  logic               xfer_s;
  logic               issue_s;
  logic [ADDR_W-1:0]  win_addr_s;
  logic [DATA_W-1:0]  win_data_s;
  logic [1:0]         win_id_s;

  rf_wr_port_t port_q, port_d;
  logic [1:0]  gid_q, gid_d;
  logic [1:0]  ptr_q, ptr_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (~hold),
    .grant_o (grant_s)
  );

  assign req_ready = grant_s;
  assign xfer_s    = |grant_s;

  // Select the granted requester's address, data and index.
  always_comb begin
    win_addr_s = '0;
    win_data_s = '0;
    win_id_s   = 2'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_s[j]) begin
        win_addr_s = req_addr[j*ADDR_W +: ADDR_W];
        win_data_s = req_data[j*DATA_W +: DATA_W];
        win_id_s   = 2'(j);
      end else begin
        win_id_s   = win_id_s;
      end
    end
  end

`ifdef RF_ZERO_DROP_EN
  assign issue_s = (win_addr_s != RF_ZERO_ADDR);
`else
  assign issue_s = 1'b1;
`endif

  // Next port state: load on a handshake, otherwise only WEN falls.
  always_comb begin
    port_d     = port_q;
    port_d.wen = 1'b0;
    gid_d      = gid_q;
    ptr_d      = ptr_q;
    if (xfer_s) begin
      port_d.wen  = issue_s;
      port_d.addr = win_addr_s;
      port_d.data = win_data_s;
      gid_d       = win_id_s;
      ptr_d       = win_id_s;
    end else begin
      ptr_d       = ptr_q;
    end
  end

  // Port registers; reset discards any pending write and re-homes the pointer.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      port_q <= '0;
      gid_q  <= 2'd0;
      ptr_q  <= 2'(NUM_REQ - 1);
    end else begin
      port_q <= port_d;
      gid_q  <= gid_d;
      ptr_q  <= ptr_d;
    end
  end

  assign WEN      = port_q.wen;
  assign RW       = port_q.addr;
  assign busW     = port_q.data;
  assign grant_id = gid_q;
  assign busy     = port_q.wen;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (2- and 3-requester instances):
// directed vector table, hand-written corner sequences, randomized model check.
module tb_rf_write_arbiter;

`ifdef RF_ZERO_DROP_EN
  localparam logic ZD = 1'b1;
`else
  localparam logic ZD = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic [1:0]  v2;  logic [5:0] a2;  logic [15:0] dd2; logic h2;
  logic [1:0]  r2;  logic wen2; logic [2:0] rw2; logic [7:0] bw2; logic [1:0] g2; logic busy2;
  logic [2:0]  v3;  logic [8:0] a3;  logic [23:0] dd3; logic h3;
  logic [2:0]  r3;  logic wen3; logic [2:0] rw3; logic [7:0] bw3; logic [1:0] g3; logic busy3;

  rf_write_arbiter #(.NUM_REQ(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .req_valid(v2), .req_addr(a2), .req_data(dd2),
    .req_ready(r2), .hold(h2), .WEN(wen2), .RW(rw2), .busW(bw2),
    .grant_id(g2), .busy(busy2)
  );

  rf_write_arbiter #(.NUM_REQ(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .req_valid(v3), .req_addr(a3), .req_data(dd3),
    .req_ready(r3), .hold(h3), .WEN(wen3), .RW(rw3), .busW(bw3),
    .grant_id(g3), .busy(busy3)
  );

  // Register file fed by dut2's write port; R0 is hardwired to zero.
  logic [7:0] rf2 [8] = '{default: 8'h00};
  always @(posedge Clk) begin
    if (wen2 && rw2 != 3'd0) rf2[rw2] <= bw2;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       h;
    logic [1:0] v;
    logic [2:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] er;
    logic       ew;
    logic [2:0] erw;
    logic [7:0] ebw;
    logic [1:0] eg;
  } vec_t;

  function automatic vec_t mk(logic h, logic [1:0] v, logic [2:0] a0, logic [2:0] a1,
                              logic [7:0] d0, logic [7:0] d1, logic [1:0] er, logic ew,
                              logic [2:0] erw, logic [7:0] ebw, logic [1:0] eg);
    vec_t r;
    r.h = h; r.v = v; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.er = er; r.ew = ew; r.erw = erw; r.ebw = ebw; r.eg = eg;
    return r;
  endfunction

  // Reference arbitration: first valid requester after the last one granted.
  function automatic int pick(int n, int last, logic h, logic [3:0] vv);
    if (h) return -1;
    for (int k = 1; k <= n; k++) begin
      if (vv[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  vec_t tbl [13];

  logic       pv  [2][4];
  logic [2:0] pa  [2][4];
  logic [7:0] pd  [2][4];
  int         wc  [2][4];
  int         nreq[2];
  int         last[2];
  int         w   [2];
  logic       hh  [2];
  logic [3:0] vv  [2];
  logic [3:0] obs [2];
  logic       mw  [2];
  logic [2:0] mrw [2];
  logic [7:0] mbw [2];
  logic [1:0] mg  [2];

  initial begin
    Rst = 1'b1;
    v2 = 2'b00; a2 = 6'd0; dd2 = 16'd0; h2 = 1'b0;
    v3 = 3'b000; a3 = 9'd0; dd3 = 24'd0; h3 = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_wen2", 32'(wen2), 32'd0);  chk("rst_rw2", 32'(rw2), 32'd0);
    chk("rst_busw2", 32'(bw2), 32'd0);  chk("rst_gid2", 32'(g2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_wen3", 32'(wen3), 32'd0);  chk("rst_gid3", 32'(g3), 32'd0);
    v2 = 2'b11;
    #1 chk("rst_prio2", 32'(r2), 32'd1);
    v2 = 2'b00;
    @(negedge Clk);
    Rst = 1'b0;

    //            h  v     a0    a1    d0     d1     er    ew     rw    bw     g
    tbl[0]  = mk(0, 2'b01, 3'd1, 3'd0, 8'hA1, 8'h00, 2'b01, 1'b1, 3'd1, 8'hA1, 2'd0);
    tbl[1]  = mk(0, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 3'd1, 8'hA1, 2'd0);
    tbl[2]  = mk(0, 2'b10, 3'd0, 3'd4, 8'h00, 8'h44, 2'b10, 1'b1, 3'd4, 8'h44, 2'd1);
    tbl[3]  = mk(0, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b01, 1'b1, 3'd2, 8'hB2, 2'd0);
    tbl[4]  = mk(0, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b10, 1'b1, 3'd3, 8'hC3, 2'd1);
    tbl[5]  = mk(0, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b01, 1'b1, 3'd2, 8'hB2, 2'd0);
    tbl[6]  = mk(0, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b10, 1'b1, 3'd3, 8'hC3, 2'd1);
    tbl[7]  = mk(1, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b00, 1'b0, 3'd3, 8'hC3, 2'd1);
    tbl[8]  = mk(1, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b00, 1'b0, 3'd3, 8'hC3, 2'd1);
    tbl[9]  = mk(1, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b00, 1'b0, 3'd3, 8'hC3, 2'd1);
    tbl[10] = mk(0, 2'b11, 3'd2, 3'd3, 8'hB2, 8'hC3, 2'b01, 1'b1, 3'd2, 8'hB2, 2'd0);
    tbl[11] = mk(0, 2'b10, 3'd0, 3'd0, 8'h00, 8'hFF, 2'b10, ~ZD,  3'd0, 8'hFF, 2'd1);
    tbl[12] = mk(0, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 3'd0, 8'hFF, 2'd1);

    for (int i = 0; i < 13; i++) begin
      @(negedge Clk);
      h2 = tbl[i].h; v2 = tbl[i].v;
      a2 = {tbl[i].a1, tbl[i].a0}; dd2 = {tbl[i].d1, tbl[i].d0};
      #1 chk($sformatf("vec%0d_ready", i), 32'(r2), 32'(tbl[i].er));
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_wen", i),  32'(wen2),  32'(tbl[i].ew));
      chk($sformatf("vec%0d_rw", i),   32'(rw2),   32'(tbl[i].erw));
      chk($sformatf("vec%0d_busw", i), 32'(bw2),   32'(tbl[i].ebw));
      chk($sformatf("vec%0d_gid", i),  32'(g2),    32'(tbl[i].eg));
      chk($sformatf("vec%0d_busy", i), 32'(busy2), 32'(tbl[i].ew));
    end
    chk("rf_r1", 32'(rf2[1]), 32'hA1);
    chk("rf_r2", 32'(rf2[2]), 32'hB2);
    chk("rf_r3", 32'(rf2[3]), 32'hC3);
    chk("rf_r4", 32'(rf2[4]), 32'h44);

    // Three requesters, all valid: strict rotation
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      v3 = 3'b111; a3 = {3'd3, 3'd2, 3'd1}; dd3 = {8'h32, 8'h31, 8'h30};
      #1 chk($sformatf("rot%0d_ready3", k), 32'(r3), 32'(1 << (k % 3)));
      @(posedge Clk);
      #1;
      chk($sformatf("rot%0d_gid3", k), 32'(g3), 32'(k % 3));
      chk($sformatf("rot%0d_wen3", k), 32'(wen3), 32'd1);
      chk($sformatf("rot%0d_rw3", k), 32'(rw3), 32'((k % 3) + 1));
    end
    @(negedge Clk);
    v3 = 3'b000;
    @(posedge Clk);
    #1 chk("rot_idle_wen3", 32'(wen3), 32'd0);

    // Reset between handshake edge and commit edge
    @(negedge Clk);
    v2 = 2'b01; a2 = {3'd0, 3'd5}; dd2 = {8'h00, 8'h55};
    @(posedge Clk);
    #1;
    chk("mid_wen_pre", 32'(wen2), 32'd1);
    chk("mid_rw_pre", 32'(rw2), 32'd5);
    v2 = 2'b00;
    #2 Rst = 1'b1;
    #1;
    chk("mid_wen_async", 32'(wen2), 32'd0);
    chk("mid_busy_async", 32'(busy2), 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1 chk("mid_rf_r5", 32'(rf2[5]), 32'h00);
    v2 = 2'b11;
    #1 chk("mid_ptr_home", 32'(r2), 32'd1);
    v2 = 2'b10;
    #1 chk("single_req1", 32'(r2), 32'd2);
    v2 = 2'b00;

    // Randomized traffic against the reference model
    nreq[0] = 2; nreq[1] = 3;
    last[0] = 1; last[1] = 2;
    for (int d = 0; d < 2; d++) begin
      mw[d] = 1'b0; mrw[d] = 3'd0; mbw[d] = 8'd0; mg[d] = 2'd0;
      for (int i = 0; i < 4; i++) begin
        pv[d][i] = 1'b0; pa[d][i] = 3'd0; pd[d][i] = 8'd0; wc[d][i] = 0;
      end
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < nreq[d]; i++) begin
          if (!pv[d][i] && $urandom_range(0, 99) < 60) begin
            pv[d][i] = 1'b1;
            pa[d][i] = 3'($urandom_range(0, 7));
            pd[d][i] = 8'($urandom_range(0, 255));
          end
        end
        hh[d] = ($urandom_range(0, 9) == 0);
        vv[d] = 4'b0000;
        for (int i = 0; i < nreq[d]; i++) vv[d][i] = pv[d][i];
        w[d] = pick(nreq[d], last[d], hh[d], vv[d]);
      end
      v2 = vv[0][1:0]; h2 = hh[0];
      a2 = {pa[0][1], pa[0][0]}; dd2 = {pd[0][1], pd[0][0]};
      v3 = vv[1][2:0]; h3 = hh[1];
      a3 = {pa[1][2], pa[1][1], pa[1][0]}; dd3 = {pd[1][2], pd[1][1], pd[1][0]};
      #1;
      chk("rnd_ready2", 32'(r2), (w[0] < 0) ? 32'd0 : 32'(1 << w[0]));
      chk("rnd_ready3", 32'(r3), (w[1] < 0) ? 32'd0 : 32'(1 << w[1]));
      obs[0] = {2'b00, r2};
      obs[1] = {1'b0, r3};
      for (int d = 0; d < 2; d++) begin
        if (obs[d] != 4'b0000) begin
          for (int i = 0; i < nreq[d]; i++) begin
            if (obs[d][i]) begin
              wc[d][i] = 0;
            end else if (pv[d][i]) begin
              wc[d][i]++;
              chk($sformatf("fair_d%0d_r%0d", d, i), 32'(wc[d][i] <= nreq[d] - 1), 32'd1);
            end
          end
        end
      end
      @(posedge Clk);
      for (int d = 0; d < 2; d++) begin
        if (w[d] >= 0) begin
          mw[d]  = ZD ? (pa[d][w[d]] != 3'd0) : 1'b1;
          mrw[d] = pa[d][w[d]];
          mbw[d] = pd[d][w[d]];
          mg[d]  = 2'(w[d]);
          last[d] = w[d];
          pv[d][w[d]] = 1'b0;
        end else begin
          mw[d] = 1'b0;
        end
      end
      #1;
      chk("rnd_wen2", 32'(wen2), 32'(mw[0]));   chk("rnd_rw2", 32'(rw2), 32'(mrw[0]));
      chk("rnd_busw2", 32'(bw2), 32'(mbw[0]));  chk("rnd_gid2", 32'(g2), 32'(mg[0]));
      chk("rnd_busy2", 32'(busy2), 32'(mw[0]));
      chk("rnd_wen3", 32'(wen3), 32'(mw[1]));   chk("rnd_rw3", 32'(rw3), 32'(mrw[1]));
      chk("rnd_busw3", 32'(bw3), 32'(mbw[1]));  chk("rnd_gid3", 32'(g3), 32'(mg[1]));
      chk("rnd_busy3", 32'(busy3), 32'(mw[1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
